// File: rtl/battleship_pkg.sv
// Shared constants for the battleship board: cell codes, command/response codes, engine states.
package battleship_pkg;

  // Stored cell codes
  localparam logic [2:0] CELL_EMPTY    = 3'd0;
  localparam logic [2:0] CELL_SHIP     = 3'd2;
  localparam logic [2:0] CELL_MISS     = 3'd4;
  localparam logic [2:0] CELL_HIT      = 3'd5;
  // Display-only overlay codes
  localparam logic [2:0] CELL_PREV_OK  = 3'd1;
  localparam logic [2:0] CELL_PREV_BAD = 3'd3;

  localparam logic [1:0] OP_PROBE = 2'd0;
  localparam logic [1:0] OP_PLACE = 2'd1;
  localparam logic [1:0] OP_SHOOT = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [2:0] RSP_OK      = 3'd0;
  localparam logic [2:0] RSP_OOB     = 3'd1;
  localparam logic [2:0] RSP_OVERLAP = 3'd2;
  localparam logic [2:0] RSP_BAD_ARG = 3'd3;
  localparam logic [2:0] RSP_MISS    = 3'd4;
  localparam logic [2:0] RSP_HIT     = 3'd5;
  localparam logic [2:0] RSP_REPEAT  = 3'd6;

  typedef enum logic [2:0] {
    ST_SWEEP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_SHOT   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // Preview overlay: a free cell shows the probe verdict, anything occupied shows as a conflict.
  function automatic logic [2:0] overlay_cell(input logic [2:0] stored, input logic ok);
    return ((stored == CELL_EMPTY) && ok) ? CELL_PREV_OK : CELL_PREV_BAD;
  endfunction

endpackage

// File: rtl/grid_ram.sv
// Board cell store: one synchronous write port, one combinational engine read port,
// one registered display read port. Linear index is y*GRID_W+x, computed by the caller.
module grid_ram #(
  parameter int DEPTH = 100,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_idx,
  input  logic [2:0]    wr_data,
  input  logic [AW-1:0] eng_idx,
  output logic [2:0]    eng_data,
  input  logic [AW-1:0] rd_idx,
  output logic [2:0]    rd_data
);

  logic [2:0] mem [DEPTH];

  // Single write port driven by the command engine.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign eng_data = mem[eng_idx];

  // Display read; a write to the same cell on the same edge shows up on the next read only.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/battleship_grid_ctrl.sv
// Battleship board controller: command engine (probe/place/shoot/clear) over grid_ram,
// ship-cell accounting, and a registered display port with preview overlay.
module battleship_grid_ctrl
  import battleship_pkg::*;
#(
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 10,
  parameter int MAX_LEN = 5,
  localparam int CW = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int NW = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_x,
  input  logic [CW-1:0] cmd_y,
  input  logic          cmd_dir,
  input  logic [LW-1:0] cmd_len,
  output logic          rsp_valid,
  output logic [2:0]    rsp_code,
  output logic [NW-1:0] ship_cells,
  output logic          all_sunk,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output logic [2:0]    rd_cell
);

  localparam int N  = GRID_W * GRID_H;
  localparam int AW = $clog2(N);
  // Wide enough that anchor+len never wraps, whichever of CW/LW is larger.
  localparam int EW = ((CW > LW) ? CW : LW) + 1;

  state_t          state, state_n;
  logic [1:0]      op_q;
  logic [CW-1:0]   x_q, y_q;
  logic            dir_q;
  logic [LW-1:0]   len_q;
  logic [NW-1:0]   k_q, k_n, ship_n;
  logic            clr_q, clr_n, placed_q, placed_n;
  logic [2:0]      rsp_n;
  logic            pv_valid, pv_ok, pv_dir, pv_load, pv_load_ok, pv_clear;
  logic [CW-1:0]   pv_x, pv_y;
  logic [LW-1:0]   pv_len;
  logic            we;
  logic [AW-1:0]   wr_idx;
  logic [2:0]      wr_data, eng_data, ram_rd;
  logic            rd_in_grid_q, rd_in_rect_q, rd_ok_q;

  logic            accept, len_bad, place_oob, shot_oob, last_cell, rd_in_grid, rd_in_rect;
  logic [EW-1:0]   cmd_end, cmd_lim, rx, ry, px, py, pv_end;
  logic [CW-1:0]   cell_x, cell_y;
  logic [NW-1:0]   cell_lin, rd_lin;

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = cmd_valid && cmd_ready;

  assign len_bad   = (cmd_len == '0) || (cmd_len > LW'(MAX_LEN));
  assign cmd_end   = EW'(cmd_dir ? cmd_y : cmd_x) + EW'(cmd_len);
  assign cmd_lim   = cmd_dir ? EW'(GRID_H) : EW'(GRID_W);
  assign place_oob = (cmd_end > cmd_lim);
  assign shot_oob  = ({1'b0, cmd_x} >= (CW+1)'(GRID_W)) || ({1'b0, cmd_y} >= (CW+1)'(GRID_H));

  // Cell k of the latched rectangle; k stays 0 for SHOOT so this is also the shot address.
  assign cell_x    = x_q + (dir_q ? '0 : k_q[CW-1:0]);
  assign cell_y    = y_q + (dir_q ? k_q[CW-1:0] : '0);
  assign cell_lin  = NW'(cell_y) * NW'(GRID_W) + NW'(cell_x);
  assign last_cell = (k_q == (NW'(len_q) - NW'(1)));

  assign rd_lin     = NW'(rd_y) * NW'(GRID_W) + NW'(rd_x);
  assign rd_in_grid = ({1'b0, rd_x} < (CW+1)'(GRID_W)) && ({1'b0, rd_y} < (CW+1)'(GRID_H));
  assign rx         = EW'(rd_x);
  assign ry         = EW'(rd_y);
  assign px         = EW'(pv_x);
  assign py         = EW'(pv_y);
  assign pv_end     = (pv_dir ? py : px) + EW'(pv_len);
  assign rd_in_rect = pv_valid && (pv_dir ? ((rx == px) && (ry >= py) && (ry < pv_end))
                                          : ((ry == py) && (rx >= px) && (rx < pv_end)));

  grid_ram #(.DEPTH(N), .AW(AW)) u_ram (
    .clk      (clk_in),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .eng_idx  (cell_lin[AW-1:0]),
    .eng_data (eng_data),
    .rd_idx   (rd_lin[AW-1:0]),
    .rd_data  (ram_rd)
  );

  // Engine state register; reset aborts any command and restarts the board sweep.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_SWEEP;
    end else begin
      state <= state_n;
    end
  end

  // Next state, RAM write, response code and accounting updates.
  always_comb begin
    state_n    = state;
    k_n        = k_q;
    clr_n      = clr_q;
    rsp_n      = rsp_code;
    ship_n     = ship_cells;
    placed_n   = placed_q;
    pv_load    = 1'b0;
    pv_load_ok = 1'b0;
    pv_clear   = 1'b0;
    we         = 1'b0;
    wr_idx     = cell_lin[AW-1:0];
    wr_data    = CELL_EMPTY;
    case (state)
      ST_SWEEP: begin
        we     = 1'b1;
        wr_idx = k_q[AW-1:0];
        if (k_q == NW'(N - 1)) begin
          k_n = '0;
          if (clr_q) begin
            state_n  = ST_RESP;
            rsp_n    = RSP_OK;
            ship_n   = '0;
            placed_n = 1'b0;
            pv_clear = 1'b1;
            clr_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          k_n = k_q + NW'(1);
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          k_n = '0;
          case (cmd_op)
            OP_PROBE, OP_PLACE: begin
              if (len_bad) begin
                state_n = ST_RESP;
                rsp_n   = RSP_BAD_ARG;
              end else if (place_oob) begin
                state_n = ST_RESP;
                rsp_n   = RSP_OOB;
                pv_load = (cmd_op == OP_PROBE);
              end else begin
                state_n = ST_CHECK;
              end
            end
            OP_SHOOT: begin
              if (shot_oob) begin
                state_n = ST_RESP;
                rsp_n   = RSP_OOB;
              end else begin
                state_n = ST_SHOT;
              end
            end
            OP_CLEAR: begin
              state_n = ST_SWEEP;
              clr_n   = 1'b1;
            end
            default: state_n = ST_IDLE;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (eng_data != CELL_EMPTY) begin
          state_n = ST_RESP;
          rsp_n   = RSP_OVERLAP;
          pv_load = (op_q == OP_PROBE);
        end else if (last_cell) begin
          if (op_q == OP_PROBE) begin
            state_n    = ST_RESP;
            rsp_n      = RSP_OK;
            pv_load    = 1'b1;
            pv_load_ok = 1'b1;
          end else begin
            state_n = ST_COMMIT;
            k_n     = '0;
          end
        end else begin
          k_n = k_q + NW'(1);
        end
      end
      ST_COMMIT: begin
        we      = 1'b1;
        wr_data = CELL_SHIP;
        if (last_cell) begin
          state_n  = ST_RESP;
          rsp_n    = RSP_OK;
          ship_n   = ship_cells + NW'(len_q);
          placed_n = 1'b1;
          pv_clear = 1'b1;
        end else begin
          k_n = k_q + NW'(1);
        end
      end
      ST_SHOT: begin
        state_n = ST_RESP;
        case (eng_data)
          CELL_EMPTY: begin
            we      = 1'b1;
            wr_data = CELL_MISS;
            rsp_n   = RSP_MISS;
          end
          CELL_SHIP: begin
            we      = 1'b1;
            wr_data = CELL_HIT;
            rsp_n   = RSP_HIT;
            ship_n  = ship_cells - NW'(1);
          end
          default: rsp_n = RSP_REPEAT;
        endcase
      end
      ST_RESP: state_n = ST_IDLE;
      default: begin
        state_n = ST_SWEEP;
        k_n     = '0;
        clr_n   = 1'b0;
      end
    endcase
  end

  // Command latch, counters, response/accounting registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      op_q       <= OP_PROBE;
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= 1'b0;
      len_q      <= '0;
      k_q        <= '0;
      clr_q      <= 1'b0;
      placed_q   <= 1'b0;
      ship_cells <= '0;
      rsp_code   <= RSP_OK;
      all_sunk   <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        x_q   <= cmd_x;
        y_q   <= cmd_y;
        dir_q <= cmd_dir;
        len_q <= cmd_len;
      end
      k_q        <= k_n;
      clr_q      <= clr_n;
      placed_q   <= placed_n;
      ship_cells <= ship_n;
      rsp_code   <= rsp_n;
      if (state_n == ST_RESP) begin
        all_sunk <= (ship_n == '0) && placed_n;
      end
    end
  end

  // Preview rectangle; an OOB probe is captured straight from the command port.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pv_valid <= 1'b0;
      pv_ok    <= 1'b0;
      pv_dir   <= 1'b0;
      pv_x     <= '0;
      pv_y     <= '0;
      pv_len   <= '0;
    end else if (pv_clear) begin
      pv_valid <= 1'b0;
    end else if (pv_load) begin
      pv_valid <= 1'b1;
      pv_ok    <= pv_load_ok;
      pv_dir   <= (state == ST_IDLE) ? cmd_dir : dir_q;
      pv_x     <= (state == ST_IDLE) ? cmd_x : x_q;
      pv_y     <= (state == ST_IDLE) ? cmd_y : y_q;
      pv_len   <= (state == ST_IDLE) ? cmd_len : len_q;
    end
  end

  // Display qualifiers registered alongside the RAM display read.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_in_grid_q <= 1'b0;
      rd_in_rect_q <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      rd_in_grid_q <= rd_in_grid;
      rd_in_rect_q <= rd_in_rect;
      rd_ok_q      <= pv_ok;
    end
  end

  // Final display code: off-grid reads are blank, preview cells take the overlay.
  always_comb begin
    rd_cell = CELL_EMPTY;
    if (!rd_in_grid_q) begin
      rd_cell = CELL_EMPTY;
    end else if (rd_in_rect_q) begin
      rd_cell = overlay_cell(ram_rd, rd_ok_q);
    end else begin
      rd_cell = ram_rd;
    end
  end

endmodule
